// File: rtl/pipeline_hazard_ctrl_if.sv
// Signal bundle between the pipeline buffers and the hazard controller.
// The master side presents buffer fields; the slave side (controller) returns controls.
interface pipeline_hazard_ctrl_if #(
  parameter int unsigned CNT_W = 16
);
  logic [3:0]       id_ra1;
  logic [3:0]       id_ra2;
  logic [3:0]       ex_ra1;
  logic [3:0]       ex_ra2;
  logic [3:0]       ex_wa3;
  logic             ex_regwrite;
  logic             ex_memtoreg;
  logic [3:0]       mem_wa3;
  logic             mem_regwrite;
  logic [3:0]       wb_wa3;
  logic             wb_regwrite;
  logic             ex_br_taken;
  logic             mem_req;
  logic             mem_ack;
  logic             if_load;
  logic             ifid_flush;
  logic             idex_load;
  logic             idex_flush;
  logic             exmem_load;
  logic [1:0]       fwd_a;
  logic [1:0]       fwd_b;
  logic [1:0]       state;
  logic [CNT_W-1:0] stall_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_ra1, id_ra2, ex_ra1, ex_ra2, ex_wa3, ex_regwrite, ex_memtoreg,
           mem_wa3, mem_regwrite, wb_wa3, wb_regwrite, ex_br_taken, mem_req, mem_ack,
    input  if_load, ifid_flush, idex_load, idex_flush, exmem_load, fwd_a, fwd_b, state,
           stall_cnt, flush_cnt
  );

  modport slave (
    input  id_ra1, id_ra2, ex_ra1, ex_ra2, ex_wa3, ex_regwrite, ex_memtoreg,
           mem_wa3, mem_regwrite, wb_wa3, wb_regwrite, ex_br_taken, mem_req, mem_ack,
    output if_load, ifid_flush, idex_load, idex_flush, exmem_load, fwd_a, fwd_b, state,
           stall_cnt, flush_cnt
  );
endinterface

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard controller for the IF/ID, ID/EX, EX/MEM buffers: load-use stalls, branch flushes,
// memory wait freezes, EX forwarding selects and saturating performance counters.
module pipeline_hazard_ctrl #(
  parameter int unsigned BRANCH_FLUSH = 2,
  parameter int unsigned CNT_W        = 16
) (
  input logic                   clk,
  input logic                   reset,
  pipeline_hazard_ctrl_if.slave io_hz
);
  localparam int unsigned FcW = (BRANCH_FLUSH > 1) ? $clog2(BRANCH_FLUSH) : 1;
  localparam logic [FcW-1:0] FlushInit = FcW'(BRANCH_FLUSH - 1);
  localparam logic [CNT_W-1:0] CntMax = '1;

  typedef enum logic [1:0] {
    StRun     = 2'd0,
    StLdStall = 2'd1,
    StMemWait = 2'd2,
    StFlush   = 2'd3
  } state_e;

  state_e           r_state, w_state_nxt;
  logic [FcW-1:0]   r_fcnt, w_fcnt_nxt;
  logic [CNT_W-1:0] r_stall_cnt, r_flush_cnt;
  logic             w_if_load, w_ifid_flush, w_idex_load, w_idex_flush, w_exmem_load;
  logic             w_br_event, w_mem_stall, w_load_use;
  logic [1:0]       w_fwd_a, w_fwd_b;

  assign w_mem_stall = io_hz.mem_req & ~io_hz.mem_ack;
  assign w_load_use  = io_hz.ex_regwrite & io_hz.ex_memtoreg &
                       ((io_hz.ex_wa3 == io_hz.id_ra1) | (io_hz.ex_wa3 == io_hz.id_ra2));

  always_comb begin
    w_state_nxt  = r_state;
    w_fcnt_nxt   = r_fcnt;
    w_if_load    = 1'b1;
    w_idex_load  = 1'b1;
    w_exmem_load = 1'b1;
    w_ifid_flush = 1'b0;
    w_idex_flush = 1'b0;
    w_br_event   = 1'b0;
    if (reset) begin
      w_if_load    = 1'b0;
      w_idex_load  = 1'b0;
      w_exmem_load = 1'b0;
      w_ifid_flush = 1'b1;
      w_idex_flush = 1'b1;
      w_state_nxt  = StRun;
      w_fcnt_nxt   = '0;
    end else if (w_mem_stall) begin
      // Freeze everything; a pending flush count is kept for after the access.
      w_if_load    = 1'b0;
      w_idex_load  = 1'b0;
      w_exmem_load = 1'b0;
      w_state_nxt  = StMemWait;
    end else if (r_state == StFlush) begin
      w_ifid_flush = 1'b1;
      w_idex_flush = 1'b1;
      w_fcnt_nxt   = (r_fcnt != '0) ? r_fcnt - 1'b1 : '0;
      w_state_nxt  = (w_fcnt_nxt == '0) ? StRun : StFlush;
    end else if (r_state == StMemWait && r_fcnt != '0) begin
      w_state_nxt = StFlush;
    end else begin
      w_state_nxt = StRun;
      if (io_hz.ex_br_taken) begin
        w_ifid_flush = 1'b1;
        w_idex_flush = 1'b1;
        w_br_event   = 1'b1;
        w_fcnt_nxt   = FlushInit;
        w_state_nxt  = (FlushInit != '0) ? StFlush : StRun;
      end else if (w_load_use && r_state != StLdStall) begin
        w_if_load    = 1'b0;
        w_idex_flush = 1'b1;
        w_state_nxt  = StLdStall;
      end
    end
  end

  always_comb begin
    w_fwd_a = 2'b00;
    w_fwd_b = 2'b00;
    if (!reset) begin
      if (io_hz.mem_regwrite && io_hz.mem_wa3 == io_hz.ex_ra1)     w_fwd_a = 2'b10;
      else if (io_hz.wb_regwrite && io_hz.wb_wa3 == io_hz.ex_ra1)  w_fwd_a = 2'b01;
      if (io_hz.mem_regwrite && io_hz.mem_wa3 == io_hz.ex_ra2)     w_fwd_b = 2'b10;
      else if (io_hz.wb_regwrite && io_hz.wb_wa3 == io_hz.ex_ra2)  w_fwd_b = 2'b01;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= StRun;
      r_fcnt      <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_fcnt  <= w_fcnt_nxt;
      if (!w_if_load && r_stall_cnt != CntMax) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_br_event && r_flush_cnt != CntMax) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign io_hz.if_load    = w_if_load;
  assign io_hz.ifid_flush = w_ifid_flush;
  assign io_hz.idex_load  = w_idex_load;
  assign io_hz.idex_flush = w_idex_flush;
  assign io_hz.exmem_load = w_exmem_load;
  assign io_hz.fwd_a      = w_fwd_a;
  assign io_hz.fwd_b      = w_fwd_b;
  // Registered values are masked while reset is held so they read as cleared immediately.
  assign io_hz.state      = reset ? 2'b00 : r_state;
  assign io_hz.stall_cnt  = reset ? '0 : r_stall_cnt;
  assign io_hz.flush_cnt  = reset ? '0 : r_flush_cnt;
endmodule
